// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// ---------------
// Computes a WIDTH-bit add or subtract with one external 1-bit full adder.
// The adder is used once per clock, starting at the LSB, so one operation
// takes WIDTH clocks in RUN plus one DONE cycle.
//
// Handshake: start is sampled only while idle (busy=0). An accepted start
// captures a, b, cin and sub in the same edge. busy stays high through RUN
// and DONE. done is a one-cycle pulse, and z/cout/overflow are valid from
// that cycle until the next done. start is ignored while busy and is never
// queued.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, a, b       request and operands
//   cin, sub          carry-in for add; sub=1 computes a + ~b + 1
//   busy, done        status and completion pulse
//   z, cout, overflow registered result, unsigned carry, signed overflow
//   add_a/add_b/add_cin  outputs to the full adder (0 outside RUN)
//   add_z/add_cout       inputs from the full adder
module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             overflow,
  output logic             add_a,
  output logic             add_b,
  output logic             add_cin,
  input  logic             add_z,
  input  logic             add_cout
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(WIDTH - 1);
  localparam logic [IDXW-1:0] IDX_PENULT = IDXW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             msb_cin_q, msb_cin_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      z_q       <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      z_q       <= z_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      msb_cin_q <= msb_cin_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    z_d       = z_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    msb_cin_d = msb_cin_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          // Subtract is folded into the operands: invert b and force carry-in.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
        end
      end
      RUN: begin
        sum_d[idx_q] = add_z;
        carry_d      = add_cout;
        idx_d        = idx_q + 1'b1;
        // Carry into the MSB is kept so overflow can be formed on the last bit.
        if (idx_q == IDX_PENULT) begin
          msb_cin_d = add_cout;
        end
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          idx_d   = '0;
          // Results are published all at once so z never shows a partial sum.
          z_d     = sum_d;
          cout_d  = add_cout;
          ovf_d   = msb_cin_q ^ add_cout;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign z        = z_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

  // Adder inputs are forced low outside RUN so the cell sees no stale operands.
  assign add_a   = (state_q == RUN) & a_q[idx_q];
  assign add_b   = (state_q == RUN) & b_q[idx_q];
  assign add_cin = (state_q == RUN) & carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: an 8-bit and a 32-bit instance, each wired
// to a behavioural 1-bit full adder. A driver issues requests and pushes
// expected results into queues; monitors compare whenever done is seen.
module tb_serial_add_ctrl;

  localparam int W8  = 8;
  localparam int W32 = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT 8-bit ----------------
  logic          start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [W8-1:0] a8 = '0, b8 = '0;
  logic          busy8, done8, cout8, ovf8;
  logic [W8-1:0] z8;
  logic          add_a8, add_b8, add_cin8, add_z8, add_cout8;

  serial_add_ctrl #(.WIDTH(W8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .busy(busy8), .done(done8), .z(z8),
    .cout(cout8), .overflow(ovf8), .add_a(add_a8), .add_b(add_b8),
    .add_cin(add_cin8), .add_z(add_z8), .add_cout(add_cout8)
  );
  assign add_z8    = add_a8 ^ add_b8 ^ add_cin8;
  assign add_cout8 = (add_a8 & add_b8) | (add_a8 & add_cin8) | (add_b8 & add_cin8);

  // ---------------- DUT 32-bit ----------------
  logic           start32 = 1'b0, cin32 = 1'b0, sub32 = 1'b0;
  logic [W32-1:0] a32 = '0, b32 = '0;
  logic           busy32, done32, cout32, ovf32;
  logic [W32-1:0] z32;
  logic           add_a32, add_b32, add_cin32, add_z32, add_cout32;

  serial_add_ctrl #(.WIDTH(W32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .busy(busy32), .done(done32), .z(z32),
    .cout(cout32), .overflow(ovf32), .add_a(add_a32), .add_b(add_b32),
    .add_cin(add_cin32), .add_z(add_z32), .add_cout(add_cout32)
  );
  assign add_z32    = add_a32 ^ add_b32 ^ add_cin32;
  assign add_cout32 = (add_a32 & add_b32) | (add_a32 & add_cin32) | (add_b32 & add_cin32);

  // ---------------- reference model ----------------
  // Result packed as {overflow, cout, z[31:0]}.
  function automatic logic [33:0] ref_add(int n, logic [31:0] x, logic [31:0] y,
                                          logic c, logic s);
    logic [63:0] mask, xx, yy, full;
    logic [31:0] zz;
    logic        sx, sy, sz;
    mask = (64'd1 << n) - 64'd1;
    xx   = {32'd0, x} & mask;
    yy   = s ? (~{32'd0, y}) & mask : {32'd0, y} & mask;
    full = xx + yy + (s ? 64'd1 : {63'd0, c});
    zz   = full[31:0] & mask[31:0];
    sx   = xx[n-1];
    sy   = yy[n-1];
    sz   = zz[n-1];
    return {((sx == sy) && (sz != sx)), full[n], zz};
  endfunction

  // Carry entering bit i of x + y + c.
  function automatic logic carry_into(int i, logic [31:0] x, logic [31:0] y, logic c);
    logic [63:0] m, s;
    m = (64'd1 << i) - 64'd1;
    s = ({32'd0, x} & m) + ({32'd0, y} & m) + {63'd0, c};
    return s[i];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard state ----------------
  logic [33:0] exp_q8[$];
  int          exp_cyc8[$];
  logic [33:0] exp_q32[$];
  int          exp_cyc32[$];
  logic [33:0] hold8  = '0;
  logic [33:0] hold32 = '0;
  int next_acc8 = 0, bs8 = -100, be8 = -100;
  int next_acc32 = 0, bs32 = -100, be32 = -100;
  logic [31:0] ca8 = '0, cb8 = '0;
  logic        cc8 = 1'b0;

  // ---------------- driver tasks ----------------
  // Drives one cycle of inputs; when the timing model says the next edge
  // accepts the request, the expected result and done cycle are queued.
  task automatic drive8(input logic st, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input logic s);
    int e;
    @(negedge clk);
    start8 = st; a8 = x; b8 = y; cin8 = c; sub8 = s;
    if (st && rst_n && (cyc + 1 >= next_acc8)) begin
      e = cyc + 1;
      exp_q8.push_back(ref_add(W8, {24'd0, x}, {24'd0, y}, c, s));
      exp_cyc8.push_back(e + W8);
      bs8 = e; be8 = e + W8; next_acc8 = e + W8 + 2;
      ca8 = {24'd0, x};
      cb8 = {24'd0, (s ? ~y : y)};
      cc8 = s ? 1'b1 : c;
    end
  endtask

  task automatic drive32(input logic st, input logic [31:0] x, input logic [31:0] y,
                         input logic c, input logic s);
    int e;
    @(negedge clk);
    start32 = st; a32 = x; b32 = y; cin32 = c; sub32 = s;
    if (st && rst_n && (cyc + 1 >= next_acc32)) begin
      e = cyc + 1;
      exp_q32.push_back(ref_add(W32, x, y, c, s));
      exp_cyc32.push_back(e + W32);
      bs32 = e; be32 = e + W32; next_acc32 = e + W32 + 2;
    end
  endtask

  // One request followed by idle cycles with scrambled operands, long enough
  // for the next request to be accepted immediately.
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s);
    drive8(1'b1, x, y, c, s);
    repeat (W8 + 1) drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
    drive32(1'b1, x, y, c, s);
    repeat (W32 + 1) drive32(1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom));
  endtask

  // ---------------- monitors ----------------
  int          ec8, ec32, i8;
  logic [33:0] ex8, ex32;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy8", busy8, (cyc >= bs8) && (cyc <= be8));
      if (done8) begin
        if (exp_q8.size() == 0) begin
          chk("done8_unexpected", done8, 1'b0);
        end else begin
          ec8 = exp_cyc8.pop_front();
          ex8 = exp_q8.pop_front();
          chk("latency8", cyc, ec8);
          chk("result8", {ovf8, cout8, 24'd0, z8}, ex8);
          hold8 = ex8;
        end
      end else begin
        if (exp_cyc8.size() > 0 && exp_cyc8[0] < cyc) begin
          chk("done8_missing", done8, 1'b1);
          void'(exp_cyc8.pop_front());
          void'(exp_q8.pop_front());
        end
        chk("hold8", {ovf8, cout8, 24'd0, z8}, hold8);
      end
      if (cyc >= bs8 && cyc < bs8 + W8) begin
        i8 = cyc - bs8;
        chk("add_a8", add_a8, ca8[i8]);
        chk("add_b8", add_b8, cb8[i8]);
        chk("add_cin8", add_cin8, carry_into(i8, ca8, cb8, cc8));
      end else begin
        chk("add_idle8", {add_a8, add_b8, add_cin8}, 3'b000);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy32", busy32, (cyc >= bs32) && (cyc <= be32));
      if (done32) begin
        if (exp_q32.size() == 0) begin
          chk("done32_unexpected", done32, 1'b0);
        end else begin
          ec32 = exp_cyc32.pop_front();
          ex32 = exp_q32.pop_front();
          chk("latency32", cyc, ec32);
          chk("result32", {ovf32, cout32, z32}, ex32);
          hold32 = ex32;
        end
      end else begin
        if (exp_cyc32.size() > 0 && exp_cyc32[0] < cyc) begin
          chk("done32_missing", done32, 1'b1);
          void'(exp_cyc32.pop_front());
          void'(exp_q32.pop_front());
        end
        chk("hold32", {ovf32, cout32, z32}, hold32);
        if (!busy32) chk("add_idle32", {add_a32, add_b32, add_cin32}, 3'b000);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state8", {busy8, done8, ovf8, cout8, z8, add_a8, add_b8, add_cin8}, '0);
    chk("rst_state32", {busy32, done32, ovf32, cout32, z32, add_a32, add_b32, add_cin32}, '0);
    rst_n = 1'b1;
    next_acc8  = cyc + 1;
    next_acc32 = cyc + 1;

    // Directed 8-bit cases, including carry, cin, signed overflow and borrow.
    run8(8'h0F, 8'h01, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b1, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 1'b0);
    run8(8'h05, 8'h07, 1'b0, 1'b1);
    run8(8'h80, 8'h01, 1'b0, 1'b1);
    run8(8'h00, 8'h00, 1'b1, 1'b1);

    // start held high with operands changing every cycle.
    repeat (30) drive8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    repeat (12) drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    // Random start pattern.
    repeat (80) drive8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                       1'($urandom), 1'($urandom));
    repeat (12) drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    // Asynchronous reset during the 4th RUN cycle.
    drive8(1'b1, 8'h5A, 8'h3C, 1'b0, 1'b0);
    for (int k = 0; k < 12 && cyc != bs8 + 3; k++) begin
      drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    chk("rst_window", cyc, bs8 + 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy_done8", {busy8, done8}, 2'b00);
    chk("arst_result8", {ovf8, cout8, z8}, '0);
    chk("arst_adder8", {add_a8, add_b8, add_cin8}, 3'b000);
    exp_q8.delete();  exp_cyc8.delete();
    exp_q32.delete(); exp_cyc32.delete();
    hold8 = '0; hold32 = '0;
    bs8 = -100; be8 = -100; bs32 = -100; be32 = -100;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    next_acc8  = cyc + 1;
    next_acc32 = cyc + 1;
    run8(8'h12, 8'h34, 1'b0, 1'b0);

    // 32-bit instance.
    run32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    run32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    repeat (4) run32($urandom, $urandom, 1'($urandom), 1'($urandom));

    // Drain with a bounded wait.
    for (int k = 0; k < 100 && (exp_q8.size() + exp_q32.size()) != 0; k++) @(negedge clk);
    chk("drain", exp_q8.size() + exp_q32.size(), 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
